// File: rtl/gpp_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, requester indices, FSM encoding.
// Pure declarations; no latency or backpressure of its own.
package gpp_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

    localparam int REQ_LOAD  = 0;
    localparam int REQ_CTRL  = 1;
    localparam int REQ_STACK = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDATA  = 2'd2
    } state_t;

    // Reduce a value in 0..5 to its index modulo 3.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-port bundle for the data-memory arbiter.
// Requesters hold req/we/addr/wdata until gnt; the memory answers reads one cycle after mem_en.
interface dmem_arbiter_if
    import gpp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt;
    logic [2:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic [2:0]          err;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, err, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, err, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters, searching from ptr and wrapping 2 -> 0.
// Zero latency; no backpressure, any=0 when nothing is requested.
module rr_pick3
    import gpp_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win,
    output logic [1:0] idx,
    output logic       any
);
    logic [1:0] cand;

    always_comb begin
        win  = 3'b000;
        idx  = 2'd0;
        any  = 1'b0;
        cand = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = wrap3({1'b0, ptr} + 3'(k));
            if (!any && req[cand]) begin
                any      = 1'b1;
                idx      = cand;
                win[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving three requesters one shared data-memory port; gnt 2 cycles after req, rvalid 1 later.
// Losers simply keep req high and are reconsidered each time the FSM returns to IDLE.
module dmem_arbiter
    import gpp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t            state;
    logic [1:0]        ptr;
    logic [1:0]        idx;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [2:0]        gnt_q;
    logic [2:0]        err_q;
    logic [2:0]        rvalid_q;
    logic              mem_en_q;

    logic [2:0]        pick_win;
    logic [1:0]        pick_idx;
    logic              pick_any;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    rr_pick3 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_we       = bus.we[pick_idx];
        sel_addr     = bus.addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        sel_wdata    = bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];
        sel_in_range = ({{(32-ADDR_W){1'b0}}, sel_addr} < DEPTH_U);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= 2'd0;
            idx       <= 2'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt_q     <= 3'b000;
            err_q     <= 3'b000;
            rvalid_q  <= 3'b000;
            mem_en_q  <= 1'b0;
        end else begin
            gnt_q    <= 3'b000;
            err_q    <= 3'b000;
            rvalid_q <= 3'b000;
            mem_en_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        idx       <= pick_idx;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        ptr       <= wrap3({1'b0, pick_idx} + 3'd1);
                        gnt_q     <= pick_win;
                        // Out-of-range accesses still get a grant so the requester can retire.
                        if (sel_in_range) mem_en_q <= 1'b1;
                        else              err_q    <= pick_win;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_en_q && !lat_we) begin
                        rvalid_q <= 3'b001 << idx;
                        state    <= S_RDATA;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                S_RDATA: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.err       = err_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_en_q & lat_we;
    assign bus.mem_addr  = mem_en_q ? lat_addr  : '0;
    assign bus.mem_wdata = mem_en_q ? lat_wdata : '0;
    // Memory data is already registered one cycle after mem_en, so it is forwarded directly.
    assign bus.rdata     = (state == S_RDATA) ? bus.mem_rdata : '0;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: write, read, contention, range error, withdrawal, reset abort.
module tb_dmem_arbiter;
    import gpp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(16)) bus ();
    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(16)) bus2 ();

    dmem_arbiter #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_arbiter #(.ADDR_W(10), .DATA_W(16), .DEPTH(768)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Memory model: registered read, 16'h1234 at 10'h3FF.
    always @(posedge clk)
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= 16'h1234 ^ {6'h00, ~bus.mem_addr};

    assign bus2.mem_rdata = 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req    = 3'b000;  bus.we    = 3'b000;
        bus.addr   = '0;      bus.wdata = '0;
        bus2.req   = 3'b000;  bus2.we   = 3'b000;
        bus2.addr  = '0;      bus2.wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b expected 000", bus.gnt); end
        checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL rst_rvalid: got %b expected 000", bus.rvalid); end
        checks++; if (bus.err !== 3'b000) begin errors++; $display("FAIL rst_err: got %b expected 000", bus.err); end
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_strobes: got en=%b we=%b expected 0 0", bus.mem_en, bus.mem_we); end
        checks++; if (bus.mem_addr !== 10'h000 || bus.mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_mem_bus: got addr=%h wdata=%h expected 0 0", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h expected 0000", bus.rdata); end
        checks++; if (bus.busy !== 1'b0 || bus2.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b/%b expected 0/0", bus.busy, bus2.busy); end
        rst = 1'b1;
    endtask

    task automatic test_write();
        bus.we = 3'b010;
        bus.addr[10 +: 10]  = 10'h005;
        bus.wdata[16 +: 16] = 16'hBEEF;
        bus.req = 3'b010;
        tick();
        checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL wr_gnt: got %b expected 010", bus.gnt); end
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_strobes: got en=%b we=%b expected 1 1", bus.mem_en, bus.mem_we); end
        checks++; if (bus.mem_addr !== 10'h005) begin errors++; $display("FAIL wr_addr: got %h expected 005", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_wdata: got %h expected beef", bus.mem_wdata); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_hi: got %b expected 1", bus.busy); end
        bus.req = 3'b000;
        tick();
        checks++; if (bus.gnt !== 3'b000 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL wr_after: got gnt=%b en=%b expected 000 0", bus.gnt, bus.mem_en); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_lo: got %b expected 0", bus.busy); end
    endtask

    task automatic test_read();
        bus.we = 3'b000;
        bus.addr[20 +: 10] = 10'h3FF;
        bus.req = 3'b100;
        tick();
        checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL rd_gnt: got %b expected 100", bus.gnt); end
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'h3FF) begin errors++; $display("FAIL rd_port: got en=%b we=%b addr=%h expected 1 0 3ff", bus.mem_en, bus.mem_we, bus.mem_addr); end
        checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL rd_early_rvalid: got %b expected 000", bus.rvalid); end
        bus.req = 3'b000;
        tick();
        checks++; if (bus.rvalid !== 3'b100) begin errors++; $display("FAIL rd_rvalid: got %b expected 100", bus.rvalid); end
        checks++; if (bus.rdata !== 16'h1234) begin errors++; $display("FAIL rd_rdata: got %h expected 1234", bus.rdata); end
        checks++; if (bus.mem_en !== 1'b0 || bus.gnt !== 3'b000 || bus.busy !== 1'b1) begin errors++; $display("FAIL rd_rdata_state: got en=%b gnt=%b busy=%b expected 0 000 1", bus.mem_en, bus.gnt, bus.busy); end
        tick();
        checks++; if (bus.rvalid !== 3'b000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rd_done: got rvalid=%b busy=%b expected 000 0", bus.rvalid, bus.busy); end
    endtask

    task automatic test_contention();
        logic [2:0]  exp_gnt [8] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        logic [15:0] exp_wd  [8] = '{16'h1111, 16'h0, 16'h2222, 16'h0, 16'h3333, 16'h0, 16'h1111, 16'h0};
        bus.we    = 3'b111;
        bus.addr  = {10'h003, 10'h002, 10'h001};
        bus.wdata = {16'h3333, 16'h2222, 16'h1111};
        bus.req   = 3'b111;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.gnt !== exp_gnt[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_gnt[i]); end
            if (exp_gnt[i] != 3'b000) begin
                checks++; if (bus.mem_wdata !== exp_wd[i]) begin errors++; $display("FAIL rr_wdata[%0d]: got %h expected %h", i, bus.mem_wdata, exp_wd[i]); end
            end
            if (i == 6) bus.req = 3'b000;
        end
    endtask

    task automatic test_out_of_range();
        bus2.we = 3'b000;
        bus2.addr[0 +: 10] = 10'h300;
        bus2.req = 3'b001;
        tick();
        checks++; if (bus2.gnt !== 3'b001 || bus2.err !== 3'b001) begin errors++; $display("FAIL oor_gnt_err: got gnt=%b err=%b expected 001 001", bus2.gnt, bus2.err); end
        checks++; if (bus2.mem_en !== 1'b0) begin errors++; $display("FAIL oor_mem_en: got %b expected 0", bus2.mem_en); end
        bus2.req = 3'b000;
        tick();
        checks++; if (bus2.rvalid !== 3'b000 || bus2.err !== 3'b000 || bus2.busy !== 1'b0) begin errors++; $display("FAIL oor_after: got rvalid=%b err=%b busy=%b expected 000 000 0", bus2.rvalid, bus2.err, bus2.busy); end
        tick();
        checks++; if (bus2.rvalid !== 3'b000) begin errors++; $display("FAIL oor_no_rvalid: got %b expected 000", bus2.rvalid); end
        bus2.we = 3'b001;
        bus2.addr[0 +: 10] = 10'h2FF;
        bus2.wdata[0 +: 16] = 16'hABCD;
        bus2.req = 3'b001;
        tick();
        checks++; if (bus2.err !== 3'b000 || bus2.mem_en !== 1'b1 || bus2.mem_addr !== 10'h2FF) begin errors++; $display("FAIL edge_in_range: got err=%b en=%b addr=%h expected 000 1 2ff", bus2.err, bus2.mem_en, bus2.mem_addr); end
        bus2.req = 3'b000;
        tick();
    endtask

    task automatic test_withdrawn();
        bus.we = 3'b101;
        bus.addr  = {10'h020, 10'h000, 10'h010};
        bus.wdata = {16'h7777, 16'h0000, 16'h5555};
        bus.req = 3'b001;
        tick();
        checks++; if (bus.gnt !== 3'b001 || bus.mem_addr !== 10'h010) begin errors++; $display("FAIL wd_first: got gnt=%b addr=%h expected 001 010", bus.gnt, bus.mem_addr); end
        bus.req = 3'b100;
        tick();
        bus.req = 3'b000;
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.gnt !== 3'b000 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL wd_idle[%0d]: got gnt=%b en=%b expected 000 0", i, bus.gnt, bus.mem_en); end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        bus.we = 3'b000;
        bus.addr[10 +: 10] = 10'h007;
        bus.req = 3'b010;
        tick();
        checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL mr_gnt: got %b expected 010", bus.gnt); end
        bus.req = 3'b000;
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mr_in_rdata: got busy=%b expected 1", bus.busy); end
        rst = 1'b0;
        #1;
        checks++; if (bus.rvalid !== 3'b000 || bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.rdata !== 16'h0000 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL mr_abort: got rvalid=%b gnt=%b busy=%b rdata=%h en=%b expected all 0", bus.rvalid, bus.gnt, bus.busy, bus.rdata, bus.mem_en); end
        tick();
        tick();
        bus.we = 3'b110;
        bus.addr = {10'h009, 10'h008, 10'h000};
        bus.req = 3'b110;
        rst = 1'b1;
        checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL mr_release_rvalid: got %b expected 000", bus.rvalid); end
        tick();
        checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL mr_first_gnt: got %b expected 010", bus.gnt); end
        bus.req = 3'b100;
        tick();
        tick();
        checks++; if (bus.gnt !== 3'b100 || bus.mem_addr !== 10'h009) begin errors++; $display("FAIL mr_second_gnt: got gnt=%b addr=%h expected 100 009", bus.gnt, bus.mem_addr); end
        bus.req = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_out_of_range();
        test_withdrawn();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, data memory address width.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter DEPTH, default 1024, number of valid memory words.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  3  access request per requester: [0] file loader, [1] control unit LDA/STA/LDR/STR, [2] stack PUSH/POP.
REQ-007 we  input  3  per-requester write enable (1 = write, 0 = read).
REQ-008 addr  input  3*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 wdata  input  3*DATA_W  per-requester write data, same packing.
REQ-010 gnt  output  3  one-hot, one-cycle pulse: the winning access is on the memory port this cycle.
REQ-011 rvalid  output  3  one-hot, one-cycle pulse: rdata holds the read result for that requester.
REQ-012 rdata  output  DATA_W  read data, valid only with rvalid.
REQ-013 err  output  3  one-cycle pulse: granted address was out of range.
REQ-014 mem_en, mem_we  output  1 each  memory port strobes.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid one cycle after a mem_en read.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RDATA.
REQ-020 IDLE: if any req bit is set, pick a winner round-robin, latch index/we/addr/wdata into registers, and go to ACCESS; otherwise stay in IDLE.
REQ-021 Round-robin: search starts at pointer ptr and wraps modulo 3 (2 -> 0); after a grant, ptr = winner+1 mod 3; ptr resets to 0.
REQ-022 ACCESS, address < DEPTH: drive mem_en=1, mem_we=latched we, mem_addr and mem_wdata from the latched values, and pulse gnt[idx].
REQ-023 ACCESS, address >= DEPTH: mem_en stays 0; pulse gnt[idx] and err[idx]; no rvalid follows; next state is IDLE.
REQ-024 ACCESS write: next state is IDLE; total latency from req sample to gnt is 2 cycles.
REQ-025 ACCESS read: next state is RDATA; in RDATA, rdata=mem_rdata and rvalid[idx] pulses; then go to IDLE.
REQ-026 Requesters SHALL hold req/we/addr/wdata until gnt; the arbiter samples them only in IDLE.
REQ-027 A request dropped before it is sampled is discarded without any access; changes after sampling are ignored.
REQ-028 Simultaneous requests: exactly one is granted per arbitration; the others wait. Each requester waits at most 2 other grants.
REQ-029 mem_en/mem_we are 0 outside ACCESS; gnt, rvalid and err are 0 except for their single-cycle pulses.
REQ-030 Throughput: one write per 2 cycles, one read per 3 cycles.

Reset
REQ-031 While rst=0: state IDLE, ptr=0, latched registers 0, and all outputs (gnt, rvalid, err, mem_en, mem_we, mem_addr, mem_wdata, rdata, busy) 0.
REQ-032 Reset during ACCESS or RDATA aborts the access: no gnt/rvalid after release; the first arbitration after release uses ptr=0.

Structure
REQ-033 Shared package gpp_pkg holds ADDR_W/DATA_W defaults, requester index constants REQ_LOAD=0, REQ_CTRL=1, REQ_STACK=2, and the FSM state encoding.
REQ-034 The combinational round-robin pick (req, ptr -> one-hot winner, index) SHALL be a sub-module rr_pick3; the FSM, registers and memory muxing stay in dmem_arbiter.

Verification
REQ-035 Single write: req=3'b010, we[1]=1, addr1=10'h005, wdata1=16'hBEEF -> gnt=3'b010 on cycle 2 with mem_en=1, mem_we=1, mem_addr=5, mem_wdata=BEEF; busy falls the following cycle.
REQ-036 Single read: req=3'b100, we[2]=0, addr2=10'h3FF, memory returns 16'h1234 -> gnt[2] on cycle 2, rvalid=3'b100 with rdata=1234 on cycle 3.
REQ-037 Contention: req=3'b111 held continuously, all writes -> grants in order 001, 010, 100, 001, spaced 2 cycles apart.
REQ-038 Out of range: DEPTH=768, requester 0 reads addr 10'h300 -> gnt[0] and err[0] pulse together, mem_en stays 0, no rvalid.
REQ-039 Reset mid-read: assert rst=0 during RDATA -> no rvalid, all outputs 0; after release, req=3'b110 -> requester 1 is granted first.
REQ-040 Withdrawn request: req[2] pulsed for 1 cycle while in ACCESS for requester 0 -> requester 2 is never granted and mem_en is not asserted for it.
